homin_step_scheduler: RTL and testbench

// Sequences one HOMIN network time step for an array of N homin_cordic_2TN neurons.
// - Builds each neuron's synaptic current from the previous step's spikes via an external weight RAM.
// - Adds the external stimulus and writes the current bank.
// - Fires the array, waits for all-ready, then captures the spike vector.
// - Replaces the behavioural step loop, so a whole run executes in hardware.

---
 rtl/homin_step_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_homin_step_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/homin_step_scheduler.sv
// Time-step sequencer for an array of N HOMIN neurons: builds each neuron's synaptic
// current from the previous step's spikes, fires the array and captures the new spikes.
module homin_step_scheduler #(
    parameter int N         = 1000,
    parameter int STEPS     = 32000,
    parameter int EXT_START = 3200,
    parameter int EXT_END   = 32000,
    parameter int TIMEOUT   = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic signed [15:0]         i_ext,
    output logic                       w_rd_en,
    output logic [$clog2(N*N)-1:0]     w_addr,
    input  logic signed [15:0]         w_rdata,
    output logic                       cur_wr_en,
    output logic [$clog2(N)-1:0]       cur_wr_idx,
    output logic signed [15:0]         cur_wr_data,
    output logic                       fire,
    input  logic                       all_ready,
    input  logic [N-1:0]               spike_vec,
    output logic                       step_valid,
    output logic [N-1:0]               spike_out,
    output logic [15:0]                step_idx,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int AW = $clog2(N*N);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [15:0]   STEP_LAST = 16'(STEPS - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_INIT_WAIT = 4'd1;
    localparam logic [3:0] S_ACCUM     = 4'd2;
    localparam logic [3:0] S_DRAIN     = 4'd3;
    localparam logic [3:0] S_WRITE     = 4'd4;
    localparam logic [3:0] S_FIRE      = 4'd5;
    localparam logic [3:0] S_WAIT      = 4'd6;
    localparam logic [3:0] S_CAPTURE   = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Two's complement wraparound add; the current bank takes no saturation.
    function automatic logic signed [15:0] wrap_add16(input logic signed [15:0] a,
                                                      input logic signed [15:0] b);
        return a + b;
    endfunction

    logic [3:0]         state_q, state_d;
    logic [IW-1:0]      i_q, i_d;
    logic [IW-1:0]      j_q, j_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic signed [31:0] acc_q, acc_d;
    logic               rd_pend_q, rd_pend_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N-1:0]       spike_prev_q, spike_prev_d;
    logic [N-1:0]       spike_out_q, spike_out_d;
    logic [15:0]        step_idx_q, step_idx_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;
    logic               step_valid_q, step_valid_d;

    logic [31:0]        step_ext;
    logic               ext_on;
    logic signed [15:0] ext_val;

    always_comb begin
        step_ext = {16'd0, step_idx_q};
        ext_on   = (step_ext >= 32'(EXT_START)) && (step_ext < 32'(EXT_END));
        ext_val  = ext_on ? i_ext : 16'sd0;
    end

    always_comb begin
        w_rd_en     = (state_q == S_ACCUM) && spike_prev_q[j_q];
        w_addr      = addr_q;
        cur_wr_en   = (state_q == S_WRITE);
        cur_wr_idx  = i_q;
        cur_wr_data = cur_wr_en ? wrap_add16(acc_q[15:0], ext_val) : 16'sd0;
        fire        = (state_q == S_FIRE);
        done        = (state_q == S_DONE);
        step_valid  = step_valid_q;
        spike_out   = spike_out_q;
        step_idx    = step_idx_q;
        busy        = busy_q;
        error       = error_q;
    end

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        addr_d       = addr_q;
        acc_d        = acc_q;
        rd_pend_d    = 1'b0;
        cnt_d        = cnt_q;
        spike_prev_d = spike_prev_q;
        spike_out_d  = spike_out_q;
        step_idx_d   = step_idx_q;
        busy_d       = busy_q;
        error_d      = error_q;
        step_valid_d = 1'b0;

        // Weight data returns one cycle after its read strobe.
        if (rd_pend_q) begin
            acc_d = acc_q + sext16(w_rdata);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d       = 1'b1;
                    error_d      = 1'b0;
                    step_idx_d   = 16'd0;
                    spike_prev_d = '0;
                    cnt_d        = '0;
                    state_d      = S_INIT_WAIT;
                end
            end
            S_INIT_WAIT: begin
                if (all_ready) begin
                    i_d     = '0;
                    j_d     = '0;
                    addr_d  = '0;
                    acc_d   = '0;
                    state_d = S_ACCUM;
                end else if (cnt_q == CNT_LAST) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ACCUM: begin
                rd_pend_d = spike_prev_q[j_q];
                addr_d    = addr_q + AW'(1);
                // step_idx advances while the previous step's step_valid is shown.
                if (step_valid_q) begin
                    step_idx_d = step_idx_q + 16'd1;
                end
                if (j_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                j_d   = '0;
                acc_d = '0;
                if (i_q == LAST_IDX) begin
                    state_d = S_FIRE;
                end else begin
                    i_d     = i_q + IW'(1);
                    state_d = S_ACCUM;
                end
            end
            S_FIRE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // First WAIT cycle is blind: neuron ready has not dropped yet.
                if ((cnt_q != '0) && all_ready) begin
                    state_d = S_CAPTURE;
                end else if (cnt_q == CNT_LAST) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CAPTURE: begin
                spike_out_d  = spike_vec;
                spike_prev_d = spike_vec;
                step_valid_d = 1'b1;
                i_d          = '0;
                j_d          = '0;
                addr_d       = '0;
                acc_d        = '0;
                if (step_idx_q == STEP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            j_q          <= '0;
            addr_q       <= '0;
            acc_q        <= '0;
            rd_pend_q    <= 1'b0;
            cnt_q        <= '0;
            spike_prev_q <= '0;
            spike_out_q  <= '0;
            step_idx_q   <= '0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            step_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            addr_q       <= addr_d;
            acc_q        <= acc_d;
            rd_pend_q    <= rd_pend_d;
            cnt_q        <= cnt_d;
            spike_prev_q <= spike_prev_d;
            spike_out_q  <= spike_out_d;
            step_idx_q   <= step_idx_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            step_valid_q <= step_valid_d;
        end
    end

endmodule

// File: tb/tb_homin_step_scheduler.sv
// Bench for homin_step_scheduler: weight RAM and neuron-array models around the DUT,
// random runs compared against a step-level current/read model.
module tb_homin_step_scheduler;

    localparam int N         = 4;
    localparam int STEPS     = 3;
    localparam int EXT_START = 1;
    localparam int EXT_END   = 3;
    localparam int TIMEOUT   = 20;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic signed [15:0] i_ext = 16'sd0;
    logic               w_rd_en;
    logic [3:0]         w_addr;
    logic signed [15:0] w_rdata = 16'sd0;
    logic               cur_wr_en;
    logic [1:0]         cur_wr_idx;
    logic signed [15:0] cur_wr_data;
    logic               fire;
    logic               all_ready;
    logic [N-1:0]       spike_vec = '0;
    logic               step_valid;
    logic [N-1:0]       spike_out;
    logic [15:0]        step_idx;
    logic               busy;
    logic               done;
    logic               error;

    homin_step_scheduler #(
        .N(N), .STEPS(STEPS), .EXT_START(EXT_START), .EXT_END(EXT_END), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .i_ext(i_ext),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .cur_wr_en(cur_wr_en), .cur_wr_idx(cur_wr_idx), .cur_wr_data(cur_wr_data),
        .fire(fire), .all_ready(all_ready), .spike_vec(spike_vec),
        .step_valid(step_valid), .spike_out(spike_out), .step_idx(step_idx),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    wire [48:0] outs = {w_rd_en, w_addr, cur_wr_en, cur_wr_idx, cur_wr_data, fire,
                        step_valid, spike_out, step_idx, busy, done, error};

    // Weight RAM and neuron array (ready low for 3 cycles after each fire).
    logic signed [15:0] wmem [0:N*N-1];
    logic [N-1:0]       plan_spk [0:STEPS-1];
    int                 rdy_cnt = 0;
    int                 fire_idx = 0;
    bit                 hold_low = 1'b0;
    bit                 model_clr = 1'b0;

    always @(posedge clk) begin
        w_rdata <= w_rd_en ? wmem[w_addr] : 16'($urandom);
        if (model_clr) begin
            rdy_cnt  <= 0;
            fire_idx <= 0;
        end else if (fire) begin
            rdy_cnt   <= 3;
            spike_vec <= (fire_idx < STEPS) ? plan_spk[fire_idx] : '0;
            fire_idx  <= fire_idx + 1;
        end else if (rdy_cnt > 0) begin
            rdy_cnt <= rdy_cnt - 1;
        end
    end

    assign all_ready = (rdy_cnt == 0) && !(hold_low && (fire_idx > 0));

    int wr_q[$];
    int rd_q[$];
    int sv_q[$];
    int done_cnt = 0;
    bit mon_clr = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            wr_q.delete();
            rd_q.delete();
            sv_q.delete();
            done_cnt = 0;
        end else begin
            if (cur_wr_en) wr_q.push_back({int'(step_idx[7:0]), 6'd0, cur_wr_idx, cur_wr_data});
            if (w_rd_en)   rd_q.push_back(int'(w_addr));
            if (step_valid) sv_q.push_back(int'(step_idx) * 16 + int'(spike_out));
            if (done) done_cnt++;
        end
    end

    int total = 0;
    int bad = 0;
    int exp_wr[$];
    int exp_rd[$];
    int exp_sv[$];

    task automatic chk(input string tag, input longint obs, input longint expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: current_i(s) = sum of W[i][j] over j that spiked in step s-1, plus ext, mod 2^16.
    task automatic build_exp(input logic signed [15:0] iext);
        logic [N-1:0] prev;
        int sum;
        int ext;
        exp_wr.delete();
        exp_rd.delete();
        exp_sv.delete();
        for (int s = 0; s < STEPS; s++) begin
            prev = (s == 0) ? '0 : plan_spk[s-1];
            ext  = (s >= EXT_START && s < EXT_END) ? int'(iext) : 0;
            for (int i = 0; i < N; i++) begin
                sum = 0;
                for (int j = 0; j < N; j++) begin
                    if (prev[j]) begin
                        sum += int'(wmem[i*N+j]);
                        exp_rd.push_back(i*N + j);
                    end
                end
                exp_wr.push_back((s << 24) | (i << 16) | ((sum + ext) & 32'hFFFF));
            end
            exp_sv.push_back(s * 16 + int'(plan_spk[s]));
        end
    endtask

    task automatic randomize_setup();
        for (int k = 0; k < N*N; k++) wmem[k] = 16'($urandom);
        for (int s = 0; s < STEPS; s++) plan_spk[s] = 4'($urandom);
    endtask

    task automatic do_run(input logic signed [15:0] iext, input bit extra, input int abort_fire,
                          output int lat, output int fire_c, output int end_c);
        int nf;
        @(posedge clk);
        model_clr = 1'b1;
        mon_clr   = 1'b1;
        @(posedge clk);
        #1;
        model_clr = 1'b0;
        mon_clr   = 1'b0;
        i_ext     = iext;
        lat = -1; fire_c = -1; end_c = -1; nf = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            start = extra && (c == 10 || c == 40 || c == 75);
            if (c == 3) begin
                chk("busy_in_run", busy, 1);
                chk("error_cleared", error, 0);
            end
            if (fire) begin
                if (lat < 0) lat = c - 1;
                fire_c = c;
                nf++;
            end
            if (hold_low && fire_c > 0 && c == fire_c + 18) chk("timeout_early", error, 0);
            if (abort_fire > 0 && nf == abort_fire && c == fire_c + 2) begin
                rst_n = 1'b0;
                #1;
                chk("abort_outs_zero", outs, 0);
                end_c = c;
                break;
            end
            if (done || error) begin
                end_c = c;
                break;
            end
        end
        start = 1'b0;
        if (end_c < 0) chk("run_bound", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_run(input string tag, input int lat);
        chk({tag, "_nwr"}, wr_q.size(), exp_wr.size());
        for (int k = 0; k < exp_wr.size(); k++)
            chk({tag, "_wr"}, (k < wr_q.size()) ? wr_q[k] : -1, exp_wr[k]);
        chk({tag, "_nrd"}, rd_q.size(), exp_rd.size());
        for (int k = 0; k < exp_rd.size(); k++)
            chk({tag, "_rd"}, (k < rd_q.size()) ? rd_q[k] : -1, exp_rd[k]);
        chk({tag, "_nsv"}, sv_q.size(), exp_sv.size());
        for (int k = 0; k < exp_sv.size(); k++)
            chk({tag, "_sv"}, (k < sv_q.size()) ? sv_q[k] : -1, exp_sv[k]);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_latency"}, lat, 1 + N*(N+2));
        chk({tag, "_final_idx"}, step_idx, STEPS - 1);
    endtask

    initial begin
        int lat, fc, ec;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", outs, 0);

        // Silent network, ext only; extra start pulses while busy.
        randomize_setup();
        for (int s = 0; s < STEPS; s++) plan_spk[s] = '0;
        build_exp(16'sd7680);
        do_run(16'sd7680, 1'b1, 0, lat, fc, ec);
        check_run("ext_only", lat);
        chk("ext_only_step1", (wr_q.size() > 4) ? (wr_q[4] & 32'hFFFF) : -1, 7680);

        // Fixed weight rows, spikes 0101 after step 0, no ext.
        randomize_setup();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) wmem[i*N+j] = 16'((j + 1) * 100);
        plan_spk[0] = 4'b0101;
        build_exp(16'sd0);
        do_run(16'sd0, 1'b0, 0, lat, fc, ec);
        check_run("rows", lat);
        chk("rows_s1_i0", (wr_q.size() > 4) ? (wr_q[4] & 32'hFFFF) : -1, 400);
        chk("rows_rd0", (rd_q.size() > 1) ? rd_q[0] : -1, 0);
        chk("rows_rd1", (rd_q.size() > 1) ? rd_q[1] : -1, 2);

        // Wraparound: 32767+32767+2 lands on 0.
        randomize_setup();
        wmem[0] = 16'sd32767; wmem[1] = 16'sd32767; wmem[2] = 16'sd0; wmem[3] = 16'sd0;
        plan_spk[0] = 4'b0011;
        build_exp(16'sd2);
        do_run(16'sd2, 1'b0, 0, lat, fc, ec);
        check_run("wrap", lat);
        chk("wrap_s1_i0", (wr_q.size() > 4) ? (wr_q[4] & 32'hFFFF) : -1, 0);

        for (int r = 0; r < 3; r++) begin
            logic signed [15:0] ie;
            randomize_setup();
            ie = 16'($urandom);
            build_exp(ie);
            do_run(ie, r[0], 0, lat, fc, ec);
            check_run("random", lat);
        end

        // all_ready stuck low after the first fire.
        randomize_setup();
        hold_low = 1'b1;
        build_exp(16'sd5);
        do_run(16'sd5, 1'b0, 0, lat, fc, ec);
        hold_low = 1'b0;
        chk("timeout_error", error, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_done", done_cnt, 0);
        chk("timeout_nsv", sv_q.size(), 0);
        chk("timeout_nwr", wr_q.size(), N);
        chk("timeout_window", (ec - fc >= TIMEOUT) && (ec - fc <= TIMEOUT + 2), 1);

        // New start after a timeout clears error and runs normally.
        randomize_setup();
        build_exp(16'sd300);
        do_run(16'sd300, 1'b0, 0, lat, fc, ec);
        check_run("recover", lat);

        // Reset while waiting on step 1, then a clean run.
        randomize_setup();
        plan_spk[0] = 4'b1111;
        build_exp(16'sd11);
        do_run(16'sd11, 1'b0, 2, lat, fc, ec);
        @(posedge clk);
        #1;
        chk("abort_outs_held", outs, 0);
        @(negedge clk);
        chk("abort_nwr", wr_q.size(), 2 * N);
        chk("abort_done", done_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        randomize_setup();
        build_exp(16'sd77);
        do_run(16'sd77, 1'b0, 0, lat, fc, ec);
        check_run("after_abort", lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
